// File: rtl/axi4_mem_pkg.sv
// Shared constants, response codes and FSM state types for the AXI4-Lite memory slave.
package axi4_mem_pkg;

    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC   = 32'd123456789;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [63:0] STALL_SEED = 64'd88172645463325252;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi4_mem_stall_gen.sv
// Free-running xorshift64 generator producing a 5-bit back-pressure mask.
// Only instantiated when AXI4_MEM_STALL_EN is defined.
module axi4_mem_stall_gen
    import axi4_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [4:0] mask
);

    logic [63:0] state_q;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;

    always_comb begin
        s1 = state_q ^ (state_q << 13);
        s2 = s1 ^ (s1 >> 7);
        s3 = s2 ^ (s2 << 17);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STALL_SEED;
        end else begin
            state_q <= s3;
        end
    end

    assign mask = state_q[4:0];

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4-Lite RAM slave with programmable read latency, console and test-pass MMIO words.
// Define AXI4_MEM_STALL_EN to add pseudo-random back-pressure on the ready/wait paths.
module axi4_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 131072,
    parameter int unsigned READ_LAT  = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                mem_axi_awvalid,
    output logic                mem_axi_awready,
    input  logic [31:0]         mem_axi_awaddr,
    input  logic [2:0]          mem_axi_awprot,

    input  logic                mem_axi_wvalid,
    output logic                mem_axi_wready,
    input  logic [DATA_W-1:0]   mem_axi_wdata,
    input  logic [DATA_W/8-1:0] mem_axi_wstrb,

    output logic                mem_axi_bvalid,
    input  logic                mem_axi_bready,
    output logic [1:0]          mem_axi_bresp,

    input  logic                mem_axi_arvalid,
    output logic                mem_axi_arready,
    input  logic [31:0]         mem_axi_araddr,
    input  logic [2:0]          mem_axi_arprot,

    output logic                mem_axi_rvalid,
    input  logic                mem_axi_rready,
    output logic [DATA_W-1:0]   mem_axi_rdata,
    output logic [1:0]          mem_axi_rresp,

    output logic                console_valid,
    output logic [7:0]          console_data,
    output logic                tests_passed
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned ADDR_W = $clog2(MEM_BYTES);
    localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

    logic [DATA_W-1:0] mem [WORDS];

    // Bits: 0 arready, 1 awready, 2 wready, 3|4 R_WAIT exit.
    logic [4:0] stall_mask;

`ifdef AXI4_MEM_STALL_EN
    axi4_mem_stall_gen u_stall_gen (
        .clk   (clk),
        .reset (reset),
        .mask  (stall_mask)
    );
`else
    assign stall_mask = '1;
`endif

    // ---------------- write path ----------------
    wr_state_e         w_state_q;
    logic              awready_q;
    logic              wready_q;
    logic              aw_full_q;
    logic              w_full_q;
    logic [31:0]       aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [31:0]       wa;
    logic              w_ram;
    logic              w_console;
    logic              w_pass;

    assign mem_axi_awready = awready_q & stall_mask[1];
    assign mem_axi_wready  = wready_q & stall_mask[2];
    assign aw_hs           = mem_axi_awvalid & mem_axi_awready;
    assign w_hs            = mem_axi_wvalid & mem_axi_wready;
    assign commit          = (w_state_q == W_IDLE) & aw_full_q & w_full_q;

    assign wa        = {aw_addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign w_ram     = wa < 32'(MEM_BYTES);
    assign w_console = wa == CONSOLE_ADDR;
    assign w_pass    = wa == PASS_ADDR;

    always_ff @(posedge clk) begin
        if (commit && w_ram) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (w_strb_q[b]) begin
                    mem[wa[ADDR_W-1:OFF_W]][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q      <= W_IDLE;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            aw_full_q      <= 1'b0;
            w_full_q       <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp  <= RESP_OKAY;
            console_valid  <= 1'b0;
            console_data   <= '0;
            tests_passed   <= 1'b0;
        end else begin
            console_valid <= 1'b0;
            unique case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        aw_full_q      <= 1'b0;
                        w_full_q       <= 1'b0;
                        mem_axi_bvalid <= 1'b1;
                        mem_axi_bresp  <= (w_ram || w_console || w_pass) ? RESP_OKAY
                                                                          : RESP_DECERR;
                        w_state_q      <= W_RESP;
                        if (w_console) begin
                            console_valid <= 1'b1;
                            console_data  <= w_data_q[7:0];
                        end
                        if (w_pass && (w_data_q[31:0] == PASS_MAGIC)) begin
                            tests_passed <= 1'b1;
                        end
                    end else begin
                        // Each latch fills independently; ready drops once its latch is full.
                        if (aw_hs) begin
                            aw_addr_q <= mem_axi_awaddr;
                            aw_full_q <= 1'b1;
                            awready_q <= 1'b0;
                        end else if (!aw_full_q) begin
                            awready_q <= 1'b1;
                        end
                        if (w_hs) begin
                            w_data_q <= mem_axi_wdata;
                            w_strb_q <= mem_axi_wstrb;
                            w_full_q <= 1'b1;
                            wready_q <= 1'b0;
                        end else if (!w_full_q) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (mem_axi_bready) begin
                        mem_axi_bvalid <= 1'b0;
                        w_state_q      <= W_IDLE;
                        awready_q      <= 1'b1;
                        wready_q       <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rd_state_e   r_state_q;
    logic        arready_q;
    logic [3:0]  lat_cnt_q;
    logic [31:0] ar_addr_q;

    logic        ar_hs;
    logic        wait_go;
    logic [31:0] ra;
    logic        r_ram;
    logic        r_mmio;

    assign mem_axi_arready = arready_q & stall_mask[0];
    assign ar_hs           = mem_axi_arvalid & mem_axi_arready;
    assign wait_go         = stall_mask[3] | stall_mask[4];

    assign ra     = {ar_addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign r_ram  = ra < 32'(MEM_BYTES);
    assign r_mmio = (ra == CONSOLE_ADDR) || (ra == PASS_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= R_IDLE;
            arready_q      <= 1'b0;
            lat_cnt_q      <= '0;
            ar_addr_q      <= '0;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
            mem_axi_rresp  <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= mem_axi_araddr;
                        lat_cnt_q <= 4'(READ_LAT);
                        arready_q <= 1'b0;
                        r_state_q <= (READ_LAT == 0) ? R_RESP : R_WAIT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (lat_cnt_q > 4'd1) begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end else if (wait_go) begin
                        lat_cnt_q <= '0;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    // First cycle loads the registered response; it is then held until rready.
                    if (!mem_axi_rvalid) begin
                        mem_axi_rvalid <= 1'b1;
                        mem_axi_rdata  <= r_ram ? mem[ra[ADDR_W-1:OFF_W]] : '0;
                        mem_axi_rresp  <= (r_ram || r_mmio) ? RESP_OKAY : RESP_DECERR;
                    end else if (mem_axi_rready) begin
                        mem_axi_rvalid <= 1'b0;
                        arready_q      <= 1'b1;
                        r_state_q      <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                           aw_addr_q[OFF_W-1:0], ar_addr_q[OFF_W-1:0]};

endmodule
